host_arb: RTL and testbench

HOST_ARB -- requirements
Module: host_arb

---
 rtl/host_arb_pkg.sv | 14 +
 rtl/host_arb_rr.sv | 34 +++
 rtl/host_arb.sv | 161 ++++++++++++++++
 tb/tb_host_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_arb_pkg.sv
// Shared types and constants for the host bus arbiter.
package host_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Read data reported when a read times out.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/host_arb_rr.sv
// Round-robin winner selection: searches upward starting one past the last
// granted requester, wrapping modulo NUM_REQ.
module host_arb_rr
  import host_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned cand;

  // First requesting index after ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/host_arb.sv
// Host bus arbiter: grants one requester at a time (round-robin), issues its
// command on the host bus and routes the read return back to it.
// Optional read timeout enabled by defining HOST_ARB_TIMEOUT_EN.
module host_arb
  import host_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_data_w,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  cmd_vld,
  output logic [31:0]           addr,
  output logic [31:0]           data_w,
  output logic                  rw,
  input  logic [31:0]           data_r,
  input  logic                  rd_vld,
  output logic                  busy,
  output logic                  stray_rd
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state, state_n;
  logic [IDX_W-1:0]   last_grant, last_grant_n;
  logic [IDX_W-1:0]   winner, winner_n;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;

  logic [NUM_REQ-1:0] req_ack_n, rsp_vld_n;
  logic [31:0]        rsp_data_n, addr_n, data_w_n;
  logic               cmd_vld_n, rw_n, stray_rd_n;

`ifdef HOST_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rsp_err_n;
`endif

  host_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req_vld),
    .ptr   (last_grant),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    winner_n     = winner;
    req_ack_n    = '0;
    rsp_vld_n    = '0;
    rsp_data_n   = '0;
    cmd_vld_n    = 1'b0;
    addr_n       = '0;
    data_w_n     = '0;
    rw_n         = 1'b0;
    stray_rd_n   = rd_vld && (state != RD_WAIT);
`ifdef HOST_ARB_TIMEOUT_EN
    cnt_n        = cnt;
    rsp_err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rr_any) begin
          state_n      = ISSUE;
          winner_n     = rr_idx;
          last_grant_n = rr_idx;
          req_ack_n    = rr_grant;
          cmd_vld_n    = 1'b1;
          addr_n       = req_addr[32*rr_idx +: 32];
          data_w_n     = req_data_w[32*rr_idx +: 32];
          rw_n         = req_rw[rr_idx];
        end
      end
      ISSUE: begin
        state_n = rw ? IDLE : RD_WAIT;
`ifdef HOST_ARB_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      RD_WAIT: begin
        if (rd_vld) begin
          state_n            = RESP;
          rsp_vld_n[winner]  = 1'b1;
          rsp_data_n         = data_r;
        end
`ifdef HOST_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
          state_n           = RESP;
          rsp_vld_n[winner] = 1'b1;
          rsp_data_n        = TIMEOUT_DATA;
          rsp_err_n         = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      winner     <= '0;
      req_ack    <= '0;
      rsp_vld    <= '0;
      rsp_data   <= '0;
      cmd_vld    <= 1'b0;
      addr       <= '0;
      data_w     <= '0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      stray_rd   <= 1'b0;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt        <= '0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      winner     <= winner_n;
      req_ack    <= req_ack_n;
      rsp_vld    <= rsp_vld_n;
      rsp_data   <= rsp_data_n;
      cmd_vld    <= cmd_vld_n;
      addr       <= addr_n;
      data_w     <= data_w_n;
      rw         <= rw_n;
      busy       <= (state_n != IDLE);
      stray_rd   <= stray_rd_n;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt        <= cnt_n;
      rsp_err    <= rsp_err_n;
`endif
    end
  end

`ifndef HOST_ARB_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_host_arb.sv
// Self-checking bench for host_arb: a transaction-level model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_host_arb;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef HOST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_vld, req_rw;
  logic [N*32-1:0] req_addr, req_data_w;
  logic [N-1:0]    req_ack, rsp_vld;
  logic [31:0]     rsp_data, addr, data_w, data_r;
  logic            rsp_err, cmd_vld, rw, rd_vld, busy, stray_rd;

  int checks = 0;
  int failures = 0;

  host_arb #(.NUM_REQ(N), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_rw(req_rw),
    .req_addr(req_addr), .req_data_w(req_data_w), .req_ack(req_ack),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cmd_vld(cmd_vld), .addr(addr), .data_w(data_w), .rw(rw),
    .data_r(data_r), .rd_vld(rd_vld), .busy(busy), .stray_rd(stray_rd)
  );

  always #5 clk = ~clk;

  // ---------------- transaction model ----------------
  // One open transaction at most: the cycle its command is on the bus and the
  // cycle its response (if a read) is presented.
  int          cyc = 0;
  bit          m_open = 0, m_rd = 0, m_err = 0;
  int          m_who = 0, m_last = N - 1, m_issue = 0, m_rsp = -1;
  logic [31:0] m_addr = '0, m_dw = '0, m_rdata = '0;
  bit          was_idle, was_issue, was_wait, was_resp, found;
  int          w;

  logic          e_cmd = 0, e_rw = 0, e_busy = 0, e_stray = 0, e_err = 0;
  logic [31:0]   e_addr = '0, e_dw = '0, e_rdata = '0;
  logic [N-1:0]  e_ack = '0, e_rsp = '0;

  // Advance the model by one clock using the inputs of the cycle just ended.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      m_open  = 0;
      m_last  = N - 1;
      m_rsp   = -1;
      e_stray = 0;
    end else begin
      was_idle  = !m_open;
      was_issue = m_open && (m_issue == cyc - 1);
      was_resp  = m_open && (m_rsp == cyc - 1);
      was_wait  = m_open && m_rd && (cyc - 1 > m_issue) && (m_rsp < 0);
      e_stray   = rd_vld && !was_wait;
      if (was_wait && rd_vld) begin
        m_rsp = cyc; m_rdata = data_r; m_err = 0;
      end else if (was_wait && TO_EN && (cyc - 1 - m_issue) == TO) begin
        m_rsp = cyc; m_rdata = 32'hDEADBEEF; m_err = 1;
      end
      if ((was_issue && !m_rd) || was_resp) begin
        m_open = 0; m_rsp = -1;
      end
      if (was_idle && req_vld != '0) begin
        found = 0; w = 0;
        for (int i = 1; i <= N; i++) begin
          if (!found && req_vld[(m_last + i) % N]) begin
            found = 1; w = (m_last + i) % N;
          end
        end
        m_open = 1; m_who = w; m_last = w; m_rd = !req_rw[w];
        m_issue = cyc; m_rsp = -1;
        m_addr = req_addr[w*32 +: 32];
        m_dw   = req_data_w[w*32 +: 32];
      end
    end
    e_busy  = m_open;
    e_cmd   = m_open && (m_issue == cyc);
    e_addr  = e_cmd ? m_addr : 32'h0;
    e_dw    = e_cmd ? m_dw : 32'h0;
    e_rw    = e_cmd && !m_rd;
    e_ack   = '0;
    e_rsp   = '0;
    if (e_cmd) e_ack[m_who] = 1'b1;
    if (m_open && m_rsp == cyc) e_rsp[m_who] = 1'b1;
    e_rdata = m_rdata;
    e_err   = m_err;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("cmd_vld",  32'(cmd_vld),  32'(e_cmd));
    chk("addr",     addr,          e_addr);
    chk("data_w",   data_w,        e_dw);
    chk("rw",       32'(rw),       32'(e_rw));
    chk("req_ack",  32'(req_ack),  32'(e_ack));
    chk("rsp_vld",  32'(rsp_vld),  32'(e_rsp));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("stray_rd", 32'(stray_rd), 32'(e_stray));
    if (e_rsp != '0) begin
      chk("rsp_data", rsp_data,     e_rdata);
      chk("rsp_err",  32'(rsp_err), 32'(e_err));
    end
  endtask

  // One cycle: compare at the falling edge, then requesters drop acked requests.
  task automatic step();
    @(negedge clk);
    cmp_model();
    req_vld = req_vld & ~req_ack;
  endtask

  task automatic set_req(input int i, input logic is_wr, input logic [31:0] a, input logic [31:0] d);
    req_rw[i]            = is_wr;
    req_addr[i*32 +: 32] = a;
    req_data_w[i*32 +: 32] = d;
    req_vld[i]           = 1'b1;
  endtask

  int ord[$];
  int ord_at[$];
  int exp_ord[5];
  int n;

  initial begin
    reset = 1'b0; req_vld = '0; req_rw = '0; req_addr = '0; req_data_w = '0;
    data_r = '0; rd_vld = 1'b0;
    exp_ord = '{0, 1, 2, 3, 0};
    repeat (3) step();
    chk("reset_busy",    32'(busy),    32'h0);
    chk("reset_cmd_vld", 32'(cmd_vld), 32'h0);
    chk("reset_req_ack", 32'(req_ack), 32'h0);
    reset = 1'b1;
    step();

    // Requester 0 write
    set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5);
    step();
    chk("wr_cmd_vld", 32'(cmd_vld), 32'h1);
    chk("wr_addr",    addr,         32'h10);
    chk("wr_data",    data_w,       32'hA5A5A5A5);
    chk("wr_rw",      32'(rw),      32'h1);
    chk("wr_ack",     32'(req_ack), 32'h1);
    step();
    chk("wr_done_cmd", 32'(cmd_vld), 32'h0);

    // Requester 1 read, data returned after 5 wait cycles
    set_req(1, 1'b0, 32'h20, 32'h0);
    step();
    chk("rd_ack", 32'(req_ack), 32'h2);
    chk("rd_rw",  32'(rw),      32'h0);
    repeat (5) step();
    data_r = 32'h12345678; rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
    chk("rd_rsp_vld",  32'(rsp_vld), 32'h2);
    chk("rd_rsp_data", rsp_data,     32'h12345678);
    chk("rd_rsp_err",  32'(rsp_err), 32'h0);
    step();

    // Fresh pointer, all four requesters keep writes pending
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'hC0DE0000 + 32'(i));
    for (int s = 0; s < 9; s++) begin
      step();
      for (int i = 0; i < N; i++)
        if (req_ack[i]) begin ord.push_back(i); ord_at.push_back(s); end
      req_vld = '1;
    end
    req_vld = '0;
    chk("rr_count", 32'(ord.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < ord.size()) begin
        chk("rr_order", 32'(ord[i]), 32'(exp_ord[i]));
        if (i > 0) chk("rr_spacing", 32'(ord_at[i] - ord_at[i-1]), 32'd2);
      end
    end
    repeat (2) step();

    // Stray rd_vld while idle
    data_r = 32'h0BAD0BAD; rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
    chk("stray_idle",     32'(stray_rd), 32'h1);
    chk("stray_idle_rsp", 32'(rsp_vld),  32'h0);
    chk("stray_idle_bsy", 32'(busy),     32'h0);
    step();
    chk("stray_clear", 32'(stray_rd), 32'h0);

    // Read by 3; requester 2 withdraws while busy; reset mid-read
    set_req(3, 1'b0, 32'h300, 32'h0);
    repeat (2) step();
    req_vld[2] = 1'b1; req_rw[2] = 1'b1;
    step();
    req_vld[2] = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_rsp",  32'(rsp_vld), 32'h0);
    reset = 1'b1; rd_vld = 1'b1; data_r = 32'h55555555;
    step();
    rd_vld = 1'b0;
    chk("rst_stray",     32'(stray_rd), 32'h1);
    chk("rst_stray_rsp", 32'(rsp_vld),  32'h0);
    chk("rst_stray_bsy", 32'(busy),     32'h0);
    repeat (2) step();

    // Read by 0 with rd_vld during ISSUE and during RESP
    set_req(0, 1'b0, 32'h44, 32'h0);
    step();
    chk("iss_ack", 32'(req_ack), 32'h1);
    data_r = 32'h00000BAD; rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
    chk("iss_stray", 32'(stray_rd), 32'h1);
    step();
    data_r = 32'hCAFE0001; rd_vld = 1'b1;
    step();
    chk("resp_data", rsp_data,     32'hCAFE0001);
    chk("resp_vld",  32'(rsp_vld), 32'h1);
    step();
    rd_vld = 1'b0;
    chk("resp_stray", 32'(stray_rd), 32'h1);
    step();

`ifdef HOST_ARB_TIMEOUT_EN
    // Read by 1 never answered
    set_req(1, 1'b0, 32'h88, 32'h0);
    step();
    n = 0;
    while (rsp_vld == '0 && n < 20) begin
      step();
      n = n + 1;
    end
    chk("to_cycles", 32'(n),       32'd9);
    chk("to_vld",    32'(rsp_vld), 32'h2);
    chk("to_err",    32'(rsp_err), 32'h1);
    chk("to_data",   rsp_data,     32'hDEADBEEF);
    repeat (2) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
